// File: rtl/wbm_spi_tx_pkg.sv
// Shared defaults for the SPI slave transmit path.
package wbm_spi_tx_pkg;

  localparam int unsigned     DEF_SIZE        = 8;
  localparam int unsigned     DEF_SYNC_STAGES = 2;
  localparam logic [7:0]      DEF_IDLE_BYTE   = 8'h00;

endpackage

// File: rtl/wbm_spi_tx_if.sv
// Level req/ack byte handshake from the wishbone domain into the SPI domain.
interface wbm_spi_tx_if #(
  parameter int unsigned SIZE = wbm_spi_tx_pkg::DEF_SIZE
);

  logic            handshake_req;
  logic [SIZE-1:0] handshake_data;
  logic            handshake_ack;

  modport master (output handshake_req, output handshake_data, input handshake_ack);
  modport slave  (input handshake_req, input handshake_data, output handshake_ack);

endinterface

// File: rtl/wbm_spi_tx_import.sv
// Import side of the handshake: req synchronizer, holding register and ack generation.
module wbm_spi_tx_import
  import wbm_spi_tx_pkg::*;
#(
  parameter int unsigned SIZE        = DEF_SIZE,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [SIZE-1:0] req_data,
  output logic            ack,
  input  logic            pop,
  output logic [SIZE-1:0] data,
  output logic            valid
);

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   capture;

  assign req_s   = req_sync[SYNC_STAGES-1];
  // A full holding register may still accept when it is being consumed on this edge.
  assign capture = req_s & ~ack & (~valid | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync <= '0;
      data     <= '0;
      valid    <= 1'b0;
      ack      <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req};
      if (capture) begin
        data  <= req_data;
        valid <= 1'b1;
        ack   <= 1'b1;
      end else begin
        if (pop)    valid <= 1'b0;
        if (!req_s) ack   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wbm_spi_tx.sv
// SPI slave transmit path: shifts handshake bytes out on spi_sdo MSB first while spi_csn is low.
module wbm_spi_tx
  import wbm_spi_tx_pkg::*;
#(
  parameter int unsigned     SIZE        = DEF_SIZE,
  parameter logic [SIZE-1:0] IDLE_BYTE   = SIZE'(DEF_IDLE_BYTE),
  parameter int unsigned     SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spi_csn,
  output logic         spi_sdo,
  wbm_spi_tx_if.slave  hs,
  output logic         underrun
);

  localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [CNT_W-1:0] cnt;
  logic [SIZE-1:0]  shift_reg;
  logic [SIZE-1:0]  hold;
  logic [SIZE-1:0]  next_word;
  logic             hold_valid;
  logic             pop;

  assign pop       = ~spi_csn & (cnt == '0);
  assign next_word = hold_valid ? hold : IDLE_BYTE;
  // First bit of a word is presented from the mux so it is valid before the first edge.
  assign spi_sdo   = (cnt == '0) ? next_word[SIZE-1] : shift_reg[SIZE-1];

  wbm_spi_tx_import #(
    .SIZE        (SIZE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_import (
    .clk      (clk),
    .rst      (rst),
    .req      (hs.handshake_req),
    .req_data (hs.handshake_data),
    .ack      (hs.handshake_ack),
    .pop      (pop),
    .data     (hold),
    .valid    (hold_valid)
  );

  // Bit counter and shift register; deselect abandons any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      shift_reg <= '0;
      underrun  <= 1'b0;
    end else if (spi_csn) begin
      cnt      <= '0;
      underrun <= 1'b0;
    end else if (cnt == '0) begin
      shift_reg <= next_word << 1;
      cnt       <= CNT_W'(1);
      underrun  <= ~hold_valid;
    end else begin
      shift_reg <= shift_reg << 1;
      cnt       <= (cnt == CNT_W'(SIZE-1)) ? '0 : cnt + CNT_W'(1);
      underrun  <= 1'b0;
    end
  end

endmodule
